// File: rtl/rr_stream_mux8_pkg.sv
// Shared types and constants for the 8-lane round-robin stream mux.
// Used by rr_stream_mux8_if, rr_arb8 and rr_stream_mux8.
package mux_pkg;

   localparam int NLANE = 8;
   localparam int SEL_W = 3;

   typedef logic [SEL_W-1:0] lane_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // Bit offset of lane k inside the packed input bus.
   function automatic int lane_slice(input int dw, input int k);
      return dw * k;
   endfunction

endpackage

// File: rtl/rr_stream_mux8_if.sv
// Lane-side and output-side stream signals of rr_stream_mux8.
// out_par exists only when RR_MUX_PARITY_EN is defined.
interface rr_stream_mux8_if #(
   parameter int DW = 4
);
   import mux_pkg::*;

   logic [NLANE*DW-1:0] in_data;
   logic [NLANE-1:0]    in_valid;
   logic [NLANE-1:0]    in_ready;
   logic [DW-1:0]       out_data;
   lane_t               out_sel;
   logic                out_valid;
   logic                out_ready;
`ifdef RR_MUX_PARITY_EN
   logic                out_par;
`endif

   modport slave (
      input  in_data, in_valid, out_ready,
`ifdef RR_MUX_PARITY_EN
      output out_par,
`endif
      output in_ready, out_data, out_sel, out_valid
   );

   modport master (
      output in_data, in_valid, out_ready,
`ifdef RR_MUX_PARITY_EN
      input  out_par,
`endif
      input  in_ready, out_data, out_sel, out_valid
   );

endinterface

// File: rtl/rr_stream_mux8_arb.sv
// rr_arb8: combinational circular priority search over 8 requests,
// starting at ptr+1 and ending at ptr itself.
module rr_arb8
   import mux_pkg::*;
(
   input  logic [NLANE-1:0] req_i,
   input  lane_t            ptr_i,
   output lane_t            gnt_idx_o,
   output logic             gnt_any_o
);

   lane_t cand;

   // Walk from lowest to highest priority so the last hit wins.
   always_comb begin
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      cand      = '0;
      for (int i = NLANE; i >= 1; i--) begin
         cand = ptr_i + lane_t'(i);
         if (req_i[cand]) begin
            gnt_idx_o = cand;
            gnt_any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_stream_mux8.sv
// rr_stream_mux8: 8-to-1 round-robin stream mux, bursts of up to BURST beats per lane,
// registered output tagged with the source lane. Optional out_par via RR_MUX_PARITY_EN.
//
// state   | meaning
// ST_IDLE | no lane holds the grant; next grant by circular search from ptr+1
// ST_HOLD | lane ptr holds the grant while valid and bcnt < BURST
module rr_stream_mux8
   import mux_pkg::*;
#(
   parameter int DW    = 4,
   parameter int BURST = 1
) (
   input logic             clk,
   input logic             rst,
   rr_stream_mux8_if.slave bus
);

   localparam logic [3:0] BURST_C = 4'(BURST);

   state_t           state_q, state_d;
   lane_t            ptr_q, ptr_d;
   logic [3:0]       bcnt_q, bcnt_d;
   logic [DW-1:0]    out_data_q;
   lane_t            out_sel_q;
   logic             out_valid_q;
   logic             load, hold_ok, arb_any, gnt_any;
   lane_t            arb_idx, gnt_idx;
   logic [DW-1:0]    gnt_data;
   logic [NLANE-1:0] ready_oh;

   rr_arb8 u_arb (
      .req_i     (bus.in_valid),
      .ptr_i     (ptr_q),
      .gnt_idx_o (arb_idx),
      .gnt_any_o (arb_any)
   );

   always_comb begin
      load     = !out_valid_q || bus.out_ready;
      hold_ok  = (state_q == ST_HOLD) && bus.in_valid[ptr_q] && (bcnt_q < BURST_C);
      gnt_idx  = hold_ok ? ptr_q : arb_idx;
      gnt_any  = hold_ok || arb_any;
      gnt_data = bus.in_data[lane_slice(DW, int'(gnt_idx)) +: DW];
      ready_oh = '0;
      if (load && gnt_any) ready_oh[gnt_idx] = 1'b1;
   end

   // A rotation grant (even back to ptr) starts a fresh burst.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      bcnt_d  = bcnt_q;
      if (load) begin
         if (!gnt_any) begin
            state_d = ST_IDLE;
         end else begin
            if (hold_ok) begin
               bcnt_d = bcnt_q + 4'd1;
            end else begin
               ptr_d  = gnt_idx;
               bcnt_d = 4'd1;
            end
            state_d = (BURST > 1) ? ST_HOLD : ST_IDLE;
         end
      end
   end

`ifdef RR_MUX_PARITY_EN
   logic out_par_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= lane_t'(NLANE - 1);
         bcnt_q      <= '0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
`ifdef RR_MUX_PARITY_EN
         out_par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         bcnt_q  <= bcnt_d;
         if (load) begin
            out_valid_q <= gnt_any;
            if (gnt_any) begin
               out_data_q <= gnt_data;
               out_sel_q  <= gnt_idx;
`ifdef RR_MUX_PARITY_EN
               out_par_q  <= ^{gnt_data, gnt_idx};
`endif
            end
         end
      end
   end

   assign bus.in_ready  = ready_oh;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;
   assign bus.out_valid = out_valid_q;
`ifdef RR_MUX_PARITY_EN
   assign bus.out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_rr_stream_mux8.sv
// Bench for rr_stream_mux8: directed scenarios on BURST=1 and BURST=3 instances,
// then randomized traffic against a burst/rotation reference model.
module tb_rr_stream_mux8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rr_stream_mux8_if #(.DW(4)) bus1 ();
   rr_stream_mux8_if #(.DW(4)) bus3 ();

   rr_stream_mux8 #(.DW(4), .BURST(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   rr_stream_mux8 #(.DW(4), .BURST(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

   // index 0 -> BURST=1 instance, index 1 -> BURST=3 instance
   logic [31:0] din  [2];
   logic [7:0]  vin  [2];
   logic        ordy [2];
   logic [7:0]  rdy  [2];
   logic [3:0]  odata[2];
   logic [2:0]  osel [2];
   logic        ovld [2];
   int          bl   [2] = '{1, 3};

   assign bus1.in_data   = din[0];
   assign bus1.in_valid  = vin[0];
   assign bus1.out_ready = ordy[0];
   assign bus3.in_data   = din[1];
   assign bus3.in_valid  = vin[1];
   assign bus3.out_ready = ordy[1];
   assign rdy[0]   = bus1.in_ready;
   assign odata[0] = bus1.out_data;
   assign osel[0]  = bus1.out_sel;
   assign ovld[0]  = bus1.out_valid;
   assign rdy[1]   = bus3.in_ready;
   assign odata[1] = bus3.out_data;
   assign osel[1]  = bus3.out_sel;
   assign ovld[1]  = bus3.out_valid;
`ifdef RR_MUX_PARITY_EN
   logic opar[2];
   assign opar[0] = bus1.out_par;
   assign opar[1] = bus3.out_par;
`endif

   int total = 0;
   int bad   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         vin[d]  = '0;
         din[d]  = '0;
         ordy[d] = 1'b1;
      end
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int d = 0; d < 2; d++) begin
         total++; if (ovld[d] !== 1'b0) begin bad++; $display("FAIL reset_valid d=%0d got=%0b exp=0", d, ovld[d]); end
         total++; if (odata[d] !== 4'h0) begin bad++; $display("FAIL reset_data d=%0d got=%0h exp=0", d, odata[d]); end
         total++; if (osel[d] !== 3'd0) begin bad++; $display("FAIL reset_sel d=%0d got=%0d exp=0", d, osel[d]); end
         total++; if (rdy[d] !== 8'h00) begin bad++; $display("FAIL reset_ready d=%0d got=%0h exp=00", d, rdy[d]); end
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] es;
      logic [3:0] ed;
      logic [7:0] er;
      do_reset();
      vin[0] = 8'hFF;
      din[0] = 32'hFEDC_BA98;
      #1;
      total++; if (rdy[0] !== 8'h01) begin bad++; $display("FAIL rr_first_ready got=%0h exp=01", rdy[0]); end
      total++; if (ovld[0] !== 1'b0) begin bad++; $display("FAIL rr_no_early_beat got=%0b exp=0", ovld[0]); end
      for (int i = 0; i < 9; i++) begin
         tick();
         es = 3'(i % 8);
         ed = 4'(i % 8 + 8);
         er = 8'(1 << ((i + 1) % 8));
         total++; if (ovld[0] !== 1'b1) begin bad++; $display("FAIL rr_valid i=%0d got=%0b exp=1", i, ovld[0]); end
         total++; if (osel[0] !== es) begin bad++; $display("FAIL rr_sel i=%0d got=%0d exp=%0d", i, osel[0], es); end
         total++; if (odata[0] !== ed) begin bad++; $display("FAIL rr_data i=%0d got=%0h exp=%0h", i, odata[0], ed); end
         total++; if (rdy[0] !== er) begin bad++; $display("FAIL rr_ready i=%0d got=%0h exp=%0h", i, rdy[0], er); end
      end
   endtask

   task automatic test_single_lane();
      for (int d = 0; d < 2; d++) begin
         do_reset();
         vin[d] = 8'h20;
         din[d] = 32'h00A0_0000;
         #1;
         for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (rdy[d] !== 8'h20) begin bad++; $display("FAIL single_ready d=%0d got=%0h exp=20", d, rdy[d]); end
            total++; if (osel[d] !== 3'd5 || odata[d] !== 4'hA || ovld[d] !== 1'b1) begin
               bad++; $display("FAIL single_beat d=%0d got=%0d/%0h/%0b exp=5/a/1", d, osel[d], odata[d], ovld[d]);
            end
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      vin[0] = 8'hFF;
      din[0] = 32'hFEDC_BA98;
      tick(); tick(); tick();
      ordy[0] = 1'b0;
      #1;
      total++; if (rdy[0] !== 8'h00) begin bad++; $display("FAIL stall_ready_now got=%0h exp=00", rdy[0]); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (ovld[0] !== 1'b1 || osel[0] !== 3'd2 || odata[0] !== 4'hA) begin
            bad++; $display("FAIL stall_hold i=%0d got=%0b/%0d/%0h exp=1/2/a", i, ovld[0], osel[0], odata[0]);
         end
         total++; if (rdy[0] !== 8'h00) begin bad++; $display("FAIL stall_ready i=%0d got=%0h exp=00", i, rdy[0]); end
      end
      ordy[0] = 1'b1;
      #1;
      total++; if (rdy[0] !== 8'h08) begin bad++; $display("FAIL stall_release_ready got=%0h exp=08", rdy[0]); end
      tick();
      total++; if (osel[0] !== 3'd3 || odata[0] !== 4'hB) begin
         bad++; $display("FAIL stall_release_beat got=%0d/%0h exp=3/b", osel[0], odata[0]);
      end
   endtask

   task automatic test_burst();
      logic [2:0] seq [9] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1};
      do_reset();
      vin[1] = 8'b0000_0110;
      din[1] = 32'h0000_0210;
      for (int i = 0; i < 9; i++) begin
         tick();
         total++; if (osel[1] !== seq[i] || odata[1] !== 4'(seq[i])) begin
            bad++; $display("FAIL burst_seq i=%0d got=%0d/%0h exp=%0d", i, osel[1], odata[1], seq[i]);
         end
      end
      do_reset();
      vin[1] = 8'b0000_0110;
      din[1] = 32'h0000_0210;
      tick(); tick();
      vin[1] = 8'b0000_0100;
      #1;
      total++; if (rdy[1] !== 8'h04) begin bad++; $display("FAIL burst_drop_ready got=%0h exp=04", rdy[1]); end
      tick();
      total++; if (osel[1] !== 3'd2) begin bad++; $display("FAIL burst_drop_sel got=%0d exp=2", osel[1]); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      vin[1] = 8'h08;
      din[1] = 32'h0000_3000;
      tick(); tick();
      total++; if (ovld[1] !== 1'b1 || osel[1] !== 3'd3) begin
         bad++; $display("FAIL midrst_pre got=%0b/%0d exp=1/3", ovld[1], osel[1]);
      end
      rst = 1'b1;
      vin[1] = 8'h09;
      din[1] = 32'h0000_3005;
      tick();
      total++; if (ovld[1] !== 1'b0 || odata[1] !== 4'h0 || osel[1] !== 3'd0) begin
         bad++; $display("FAIL midrst_clear got=%0b/%0h/%0d exp=0/0/0", ovld[1], odata[1], osel[1]);
      end
      rst = 1'b0;
      #1;
      total++; if (rdy[1] !== 8'h01) begin bad++; $display("FAIL midrst_first_ready got=%0h exp=01", rdy[1]); end
      tick();
      total++; if (ovld[1] !== 1'b1 || osel[1] !== 3'd0 || odata[1] !== 4'h5) begin
         bad++; $display("FAIL midrst_first_beat got=%0b/%0d/%0h exp=1/0/5", ovld[1], osel[1], odata[1]);
      end
   endtask

`ifdef RR_MUX_PARITY_EN
   task automatic test_parity();
      do_reset();
      total++; if (opar[0] !== 1'b0) begin bad++; $display("FAIL par_reset got=%0b exp=0", opar[0]); end
      vin[0] = 8'h04;
      din[0] = 32'h0000_0B00;
      tick();
      total++; if (osel[0] !== 3'd2 || odata[0] !== 4'hB || opar[0] !== 1'b0) begin
         bad++; $display("FAIL par_b_2 got=%0d/%0h/%0b exp=2/b/0", osel[0], odata[0], opar[0]);
      end
      vin[0] = 8'h01;
      din[0] = 32'h0000_0001;
      tick();
      total++; if (osel[0] !== 3'd0 || odata[0] !== 4'h1 || opar[0] !== 1'b1) begin
         bad++; $display("FAIL par_1_0 got=%0d/%0h/%0b exp=0/1/1", osel[0], odata[0], opar[0]);
      end
   endtask
`endif

   // Reference model: the lane of the current burst, its length so far, and whether
   // a burst is live; the output beat is what the last granted lane offered.
   int         m_last [2];
   int         m_run  [2];
   bit         m_live [2];
   bit         m_ov   [2];
   logic [3:0] m_od   [2];
   logic [2:0] m_os   [2];

   task automatic test_random();
      int         g      [2];
      bit         hold   [2];
      bit         ld     [2];
      logic [7:0] mxfer  [2];
      logic [7:0] dxfer  [2];
      logic [7:0] pv     [2];
      logic [31:0] pd    [2];
      logic [7:0] er;
      do_reset();
      for (int d = 0; d < 2; d++) begin
         m_last[d] = 7; m_run[d] = 0; m_live[d] = 0;
         m_ov[d] = 0; m_od[d] = 0; m_os[d] = 0;
         mxfer[d] = 8'hFF; dxfer[d] = 8'hFF; pv[d] = 8'h00; pd[d] = '0;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) begin
               if (!vin[d][k] || mxfer[d][k]) begin
                  vin[d][k] = ($urandom_range(0, 99) < 45);
                  din[d][4*k +: 4] = 4'($urandom_range(0, 15));
               end
            end
            ordy[d] = ($urandom_range(0, 99) < 70);
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            // sources must hold an offered beat until the DUT takes it
            for (int k = 0; k < 8; k++) begin
               if (pv[d][k] && !dxfer[d][k]) begin
                  total++;
                  if (!vin[d][k] || din[d][4*k +: 4] !== pd[d][4*k +: 4]) begin
                     bad++; $display("FAIL rnd_protocol d=%0d c=%0d lane=%0d dropped before taken", d, c, k);
                  end
               end
            end
            ld[d] = !m_ov[d] || ordy[d];
            hold[d] = m_live[d] && vin[d][m_last[d]] && (m_run[d] < bl[d]);
            g[d] = -1;
            if (hold[d]) g[d] = m_last[d];
            else begin
               for (int s = 8; s >= 1; s--) if (vin[d][(m_last[d] + s) % 8]) g[d] = (m_last[d] + s) % 8;
            end
            er = (ld[d] && g[d] >= 0) ? 8'(1 << g[d]) : 8'h00;
            total++; if (rdy[d] !== er) begin bad++; $display("FAIL rnd_ready d=%0d c=%0d got=%0h exp=%0h", d, c, rdy[d], er); end
            mxfer[d] = er;
            dxfer[d] = rdy[d] & vin[d];
            pv[d] = vin[d];
            pd[d] = din[d];
         end
         tick();
         for (int d = 0; d < 2; d++) begin
            if (ld[d]) begin
               if (g[d] < 0) begin
                  m_ov[d] = 0;
                  m_live[d] = 0;
               end else begin
                  m_ov[d] = 1;
                  m_od[d] = din[d][4*g[d] +: 4];
                  m_os[d] = 3'(g[d]);
                  if (hold[d]) m_run[d]++;
                  else begin m_last[d] = g[d]; m_run[d] = 1; end
                  m_live[d] = (bl[d] > 1);
               end
            end
            total++; if (ovld[d] !== m_ov[d] || odata[d] !== m_od[d] || osel[d] !== m_os[d]) begin
               bad++; $display("FAIL rnd_out d=%0d c=%0d got=%0b/%0h/%0d exp=%0b/%0h/%0d",
                               d, c, ovld[d], odata[d], osel[d], m_ov[d], m_od[d], m_os[d]);
            end
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         vin[d] = '0; din[d] = '0; ordy[d] = 1'b1;
      end
      test_reset();
      test_round_robin();
      test_single_lane();
      test_stall();
      test_burst();
      test_reset_mid();
`ifdef RR_MUX_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
